cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 Parameter: BLOCK_WORDS, 8, 16-bit words per cache block; fixed at 8 (3-bit word index).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 icache_miss  in  1  I-cache block miss pending; held high until icache_fill_done.
REQ-005 icache_addr  in  16  I-cache miss byte address.
REQ-006 dcache_miss  in  1  D-cache block miss pending; held high until dcache_fill_done.
REQ-007 dcache_addr  in  16  D-cache miss byte address.
REQ-008 mem_data_valid  in  1  main memory read data valid this cycle.
REQ-009 mem_data  in  16  main memory read data.
REQ-010 mem_en  out  1  memory read issue strobe.
REQ-011 mem_addr  out  16  memory read byte address.
REQ-012 icache_grant / dcache_grant  out  1 each  owner of the current fill.
REQ-013 fill_we_i / fill_we_d  out  1 each  write fill_data into I-/D-cache data array.
REQ-014 fill_idx  out  3  word index of fill_data within the block.
REQ-015 fill_data  out  16  mem_data passed through.
REQ-016 icache_fill_done / dcache_fill_done  out  1 each  one-cycle fill-complete pulse.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE: any miss high -> latch winner, block base = addr & 16'hFFF0, go ISSUE next cycle; no miss -> stay.
REQ-020 Both misses high in IDLE -> winner chosen per REQ-032/033.
REQ-021 ISSUE: mem_en=1 for exactly 8 consecutive cycles, mem_addr = base + 2*k, k = 0..7 from 3-bit issue counter; after k=7 go DRAIN.
REQ-022 Return counter (4-bit) increments on each mem_data_valid while in ISSUE or DRAIN; fill_idx = low 3 bits of return counter.
REQ-023 fill_we_i = mem_data_valid & icache_grant & (ISSUE|DRAIN); fill_we_d likewise with dcache_grant; never both.
REQ-024 Return counter reaching 8 -> DONE next cycle; returns may overlap ISSUE.
REQ-025 DONE: exactly one cycle, winner's *_fill_done=1, grant still held; then IDLE, counters cleared.
REQ-026 Grant held from the cycle after latching through DONE inclusive; deasserted in IDLE.
REQ-027 mem_data_valid in IDLE or DONE ignored (no fill_we, no count).
REQ-028 Miss deasserted mid-fill: ignored, fill runs to completion, done pulse still issued.
REQ-029 Miss still high during the DONE cycle is not re-arbitrated until IDLE (earliest new latch: the IDLE cycle after DONE).
REQ-030 mem_addr = 0 whenever mem_en = 0.

Reset
REQ-031 rst high -> immediately IDLE; counters, base, grants, mem_en, mem_addr, fill_we_*, fill_idx, fill_data (registered 0 when no valid), *_fill_done, busy all 0; in-flight memory returns after reset ignored per REQ-027.

Configuration
REQ-032 Macro FILL_ARB_RR_EN defined: round-robin; 1-bit last-winner register (reset value = I-cache) and simultaneous misses go to the requester that did not win last.
REQ-033 FILL_ARB_RR_EN undefined: fixed priority, D-cache always wins simultaneous misses; no last-winner register.

Verification
REQ-034 Memory model latency 4 (valid 4 cycles after mem_en). I-miss only, icache_addr=16'h0124 at cycle 0 -> mem_addr 0x0120..0x012E cycles 1..8, fill_we_i cycles 5..12 idx 0..7, icache_fill_done cycle 13, busy cycles 1..13.
REQ-035 Both misses cycle 0 (0x0040 I, 0x8008 D), macro undefined -> D fill first (0x8000..0x800E), I fill latched in IDLE after D DONE; repeat with FILL_ARB_RR_EN: D first, then I, then a second simultaneous pair grants I first.
REQ-036 rst pulsed at cycle 6 of a fill -> all outputs 0 same cycle; stray mem_data_valid cycles 7..12 produce no fill_we; later miss fills correctly from idx 0.
REQ-037 dcache_miss dropped at cycle 3 -> 8 fill_we_d pulses and dcache_fill_done still produced; no new fill starts.
REQ-038 Back-to-back I-misses (miss held through DONE) -> second issue begins exactly 2 cycles after DONE cycle (IDLE latch, then ISSUE); no mem_en gap overlap.

Source files
------------

// File: rtl/cache_fill_arbiter_if.sv
// Handshake bundle between the I/D caches, main memory and the fill arbiter.
// master = cache/memory side, slave = arbiter.
interface cache_fill_arbiter_if;
  logic        icache_miss;
  logic [15:0] icache_addr;
  logic        dcache_miss;
  logic [15:0] dcache_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        icache_grant;
  logic        dcache_grant;
  logic        fill_we_i;
  logic        fill_we_d;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        icache_fill_done;
  logic        dcache_fill_done;
  logic        busy;

  modport master (
    output icache_miss, icache_addr, dcache_miss, dcache_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, icache_grant, dcache_grant, fill_we_i, fill_we_d,
           fill_idx, fill_data, icache_fill_done, dcache_fill_done, busy
  );

  modport slave (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, icache_grant, dcache_grant, fill_we_i, fill_we_d,
           fill_idx, fill_data, icache_fill_done, dcache_fill_done, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache block misses onto one memory read port and streams the fill back.
// Optional FILL_ARB_RR_EN: round-robin on simultaneous misses (default: D-cache priority).
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input logic                 clk,
  input logic                 rst,
  cache_fill_arbiter_if.slave bus
);
  localparam int LAST = BLOCK_WORDS - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state, stateNext;
  logic [2:0]  issueCnt;
  logic [3:0]  retCnt;
  logic [15:0] base;
  logic        grantI, grantD;
  logic        active, retLast, latch, pickD, both;
  logic        weI, weD;

  assign active  = (state == ISSUE) || (state == DRAIN);
  assign latch   = (state == IDLE) && (bus.icache_miss || bus.dcache_miss);
  assign both    = bus.icache_miss && bus.dcache_miss;
  // Final return is seen combinationally so DONE follows the 8th write directly.
  assign retLast = active && bus.mem_data_valid && (retCnt == 4'(LAST));

`ifdef FILL_ARB_RR_EN
  // Last winner of a contested arbitration only; 0 = I-cache.
  logic lastD;
  assign pickD = both ? !lastD : bus.dcache_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                lastD <= 1'b0;
    else if (latch && both) lastD <= pickD;
  end
`else
  assign pickD = bus.dcache_miss;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (latch) stateNext = ISSUE;
      ISSUE:   if (issueCnt == 3'(LAST)) stateNext = retLast ? DONE : DRAIN;
      DRAIN:   if (retLast) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      issueCnt <= '0;
      retCnt   <= '0;
      base     <= '0;
      grantI   <= 1'b0;
      grantD   <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          issueCnt <= '0;
          retCnt   <= '0;
          if (latch) begin
            grantD <= pickD;
            grantI <= !pickD;
            base   <= (pickD ? bus.dcache_addr : bus.icache_addr) & 16'hFFF0;
          end
        end
        ISSUE, DRAIN: begin
          if (state == ISSUE)     issueCnt <= issueCnt + 3'd1;
          if (bus.mem_data_valid) retCnt   <= retCnt + 4'd1;
        end
        default: begin
          issueCnt <= '0;
          retCnt   <= '0;
          base     <= '0;
          grantI   <= 1'b0;
          grantD   <= 1'b0;
        end
      endcase
    end
  end

  assign weI = active && bus.mem_data_valid && grantI;
  assign weD = active && bus.mem_data_valid && grantD;

  assign bus.mem_en           = (state == ISSUE);
  assign bus.mem_addr         = (state == ISSUE) ? base + {12'd0, issueCnt, 1'b0} : 16'd0;
  assign bus.icache_grant     = grantI;
  assign bus.dcache_grant     = grantD;
  assign bus.fill_we_i        = weI;
  assign bus.fill_we_d        = weD;
  assign bus.fill_idx         = retCnt[2:0];
  assign bus.fill_data        = (weI || weD) ? bus.mem_data : 16'd0;
  assign bus.icache_fill_done = (state == DONE) && grantI;
  assign bus.dcache_fill_done = (state == DONE) && grantD;
  assign bus.busy             = (state != IDLE);
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench: directed fill scenarios plus random miss mixes against a
// timeline model of a fill (latency-4 memory, fixed 14-cycle fill window).
module tb_cache_fill_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic strayValid = 1'b0;
  bit   lastContestD = 1'b0;

  cache_fill_arbiter_if bus ();
  cache_fill_arbiter #(.BLOCK_WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Memory: data returns 4 cycles after mem_en; not reset, so in-flight returns survive rst.
  logic [3:0]       vPipe = '0;
  logic [3:0][15:0] aPipe = '0;
  always @(posedge clk) begin
    vPipe <= {vPipe[2:0], bus.mem_en};
    aPipe <= {aPipe[2:0], bus.mem_addr};
  end

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign bus.mem_data_valid = vPipe[3] | strayValid;
  assign bus.mem_data       = memFn(aPipe[3]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_flags"}, {bus.busy, bus.mem_en, bus.icache_grant, bus.dcache_grant,
                          bus.fill_we_i, bus.fill_we_d, bus.icache_fill_done, bus.dcache_fill_done}, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_idx"},  bus.fill_idx, 0);
    chk({tag, "_data"}, bus.fill_data, 0);
  endtask

  // Called in cycle 0 (the IDLE latch cycle) with misses already driven.
  task automatic fillCheck(input bit ownD, input logic [15:0] addr, input int dropC, input bit hold);
    logic [15:0] base;
    bit en, we;
    base = addr & 16'hFFF0;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == dropC || (c == 13 && !hold)) begin
          if (ownD) bus.dcache_miss = 1'b0;
          else      bus.icache_miss = 1'b0;
        end
      end
      @(negedge clk);
      en = (c >= 1 && c <= 8);
      we = (c >= 5 && c <= 12);
      chk("busy",    bus.busy, c >= 1);
      chk("grant_i", bus.icache_grant, c >= 1 && !ownD);
      chk("grant_d", bus.dcache_grant, c >= 1 && ownD);
      chk("mem_en",  bus.mem_en, en);
      chk("mem_addr", bus.mem_addr, en ? base + 16'(2 * (c - 1)) : 16'd0);
      chk("fill_we_i", bus.fill_we_i, we && !ownD);
      chk("fill_we_d", bus.fill_we_d, we && ownD);
      if (we) begin
        chk("fill_idx",  bus.fill_idx, c - 5);
        chk("fill_data", bus.fill_data, memFn(base + 16'(2 * (c - 5))));
      end
      chk("done_i", bus.icache_fill_done, c == 13 && !ownD);
      chk("done_d", bus.dcache_fill_done, c == 13 && ownD);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  function automatic bit contestWinnerD();
`ifdef FILL_ARB_RR_EN
    bit w;
    w = !lastContestD;
    lastContestD = w;
    return w;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    bit winD;
    int mode;
    logic [15:0] ia, da;
    bus.icache_miss = 0; bus.icache_addr = 0;
    bus.dcache_miss = 0; bus.dcache_addr = 0;
    #2;
    chkZero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    nextCycle();

    // Single I-miss at 0x0124
    bus.icache_miss = 1; bus.icache_addr = 16'h0124;
    fillCheck(1'b0, 16'h0124, -1, 1'b0);
    nextCycle();
    @(negedge clk); chk("idle_after_i", bus.busy, 0);
    nextCycle();

    // Simultaneous misses: winner first, loser latched in the IDLE after DONE
    bus.icache_miss = 1; bus.icache_addr = 16'h0040;
    bus.dcache_miss = 1; bus.dcache_addr = 16'h8008;
    winD = contestWinnerD();
    fillCheck(winD, winD ? 16'h8008 : 16'h0040, -1, 1'b0);
    nextCycle();
    fillCheck(!winD, winD ? 16'h0040 : 16'h8008, -1, 1'b0);
    nextCycle();
    // Second contested pair
    bus.icache_miss = 1; bus.dcache_miss = 1;
    winD = contestWinnerD();
    fillCheck(winD, winD ? 16'h8008 : 16'h0040, -1, 1'b0);
    nextCycle();
    fillCheck(!winD, winD ? 16'h0040 : 16'h8008, -1, 1'b0);
    nextCycle();

    // D-miss dropped mid-fill still completes; nothing restarts
    bus.dcache_miss = 1; bus.dcache_addr = 16'hBEEF;
    fillCheck(1'b1, 16'hBEEF, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      @(negedge clk);
      chk("drop_idle_busy", bus.busy, 0);
      chk("drop_idle_en", bus.mem_en, 0);
    end
    nextCycle();

    // Back-to-back I-miss held through DONE: relatch one cycle after DONE
    bus.icache_miss = 1; bus.icache_addr = 16'h2222;
    fillCheck(1'b0, 16'h2222, -1, 1'b1);
    nextCycle();
    fillCheck(1'b0, 16'h2222, -1, 1'b0);
    nextCycle();

    // Reset mid-fill, then stray returns are ignored
    bus.icache_miss = 1; bus.icache_addr = 16'h3456;
    repeat (6) nextCycle();
    rst = 1; bus.icache_miss = 0;
    #1 chkZero("midreset");
    for (int c = 7; c <= 12; c++) begin
      nextCycle();
      rst = 0; strayValid = 1;
      @(negedge clk);
      chk("stray_we_i", bus.fill_we_i, 0);
      chk("stray_we_d", bus.fill_we_d, 0);
      chk("stray_busy", bus.busy, 0);
    end
    nextCycle();
    strayValid = 0;
    repeat (2) nextCycle();
    bus.icache_miss = 1;
    fillCheck(1'b0, 16'h3456, -1, 1'b0);
    nextCycle();

    // Random miss mixes
    for (int n = 0; n < 8; n++) begin
      mode = $urandom_range(0, 2);
      ia = 16'($urandom); da = 16'($urandom);
      bus.icache_addr = ia; bus.dcache_addr = da;
      if (mode == 0) begin
        bus.icache_miss = 1;
        fillCheck(1'b0, ia, -1, 1'b0);
      end else if (mode == 1) begin
        bus.dcache_miss = 1;
        fillCheck(1'b1, da, int'($urandom_range(1, 15)), 1'b0);
      end else begin
        bus.icache_miss = 1; bus.dcache_miss = 1;
        winD = contestWinnerD();
        fillCheck(winD, winD ? da : ia, -1, 1'b0);
        nextCycle();
        fillCheck(!winD, winD ? ia : da, -1, 1'b0);
      end
      nextCycle();
      @(negedge clk);
      chk("rand_idle", bus.busy, 0);
      nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
